// File: rtl/commit_pkg.sv
// Shared widths and the commit state type for the commit unit and its write-back slots.
package commit_pkg;
  localparam int DATA_W = 16;
  localparam int AREG_W = 3;
  localparam int TAG_W  = 6;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } commit_state_t;
endpackage

// File: rtl/commit_wb_slot.sv
// One registered register-file write port plus its busy-clear request.
// suppress drops the write and the clear, which is how same-destination collapse works.
module commit_wb_slot
  import commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              retire,
  input  logic              wb,
  input  logic              suppress,
  input  logic [AREG_W-1:0] rd,
  input  logic [DATA_W-1:0] value,
  input  logic [TAG_W-1:0]  tag,
  output logic              wen,
  output logic [AREG_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              clr_en,
  output logic [AREG_W-1:0] clr_rd,
  output logic [TAG_W-1:0]  clr_tag
);

  logic fire;
  assign fire = retire & wb & ~suppress;

  always_ff @(posedge clk) begin
    if (rst) begin
      wen     <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      clr_en  <= 1'b0;
      clr_rd  <= '0;
      clr_tag <= '0;
    end else begin
      wen    <= fire;
      clr_en <= fire;
      // address/data/tag hold their last value while the port is idle
      if (fire) begin
        waddr   <= rd;
        wdata   <= value;
        clr_rd  <= rd;
        clr_tag <= tag;
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Dual-wide in-order commit from the ROB head; registered RF writes and busy clears.
// Optional retired-entry counter is built when COMMIT_STATS_EN is defined.
//
//   state  | meaning
//   RUN    | retiring up to two ready head entries per cycle
//   HALTED | a halt entry has retired; nothing retires until rst
module commit_unit
  import commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              h0_valid,
  input  logic              h0_ready,
  input  logic              h0_wb,
  input  logic              h0_halt,
  input  logic [AREG_W-1:0] h0_rd,
  input  logic [DATA_W-1:0] h0_value,
  input  logic [TAG_W-1:0]  h0_tag,
  input  logic              h1_valid,
  input  logic              h1_ready,
  input  logic              h1_wb,
  input  logic              h1_halt,
  input  logic [AREG_W-1:0] h1_rd,
  input  logic [DATA_W-1:0] h1_value,
  input  logic [TAG_W-1:0]  h1_tag,
  output logic [1:0]        retire_cnt,
  output logic              wen0,
  output logic [AREG_W-1:0] waddr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              wen1,
  output logic [AREG_W-1:0] waddr1,
  output logic [DATA_W-1:0] wdata1,
  output logic              clr0_en,
  output logic [AREG_W-1:0] clr0_rd,
  output logic [TAG_W-1:0]  clr0_tag,
  output logic              clr1_en,
  output logic [AREG_W-1:0] clr1_rd,
  output logic [TAG_W-1:0]  clr1_tag,
  output logic              halted,
  output logic [31:0]       retired_total
);

  commit_state_t state, state_nxt;
  logic ret0, ret1, collapse;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ret0       = 1'b0;
    ret1       = 1'b0;
    collapse   = 1'b0;
    retire_cnt = 2'd0;
    if (state == RUN && !rst) begin
      ret0 = h0_valid & h0_ready;
      ret1 = ret0 & ~h0_halt & h1_valid & h1_ready;
      // only the younger value reaches a shared destination
      collapse   = ret0 & ret1 & h0_wb & h1_wb & (h0_rd == h1_rd);
      retire_cnt = {1'b0, ret0} + {1'b0, ret1};
      if ((ret0 & h0_halt) | (ret1 & h1_halt)) state_nxt = HALTED;
    end
  end

  assign halted = (state == HALTED);

  commit_wb_slot u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .retire  (ret0),
    .wb      (h0_wb),
    .suppress(collapse),
    .rd      (h0_rd),
    .value   (h0_value),
    .tag     (h0_tag),
    .wen     (wen0),
    .waddr   (waddr0),
    .wdata   (wdata0),
    .clr_en  (clr0_en),
    .clr_rd  (clr0_rd),
    .clr_tag (clr0_tag)
  );

  commit_wb_slot u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .retire  (ret1),
    .wb      (h1_wb),
    .suppress(1'b0),
    .rd      (h1_rd),
    .value   (h1_value),
    .tag     (h1_tag),
    .wen     (wen1),
    .waddr   (waddr1),
    .wdata   (wdata1),
    .clr_en  (clr1_en),
    .clr_rd  (clr1_rd),
    .clr_tag (clr1_tag)
  );

`ifdef COMMIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) retired_total <= '0;
    else     retired_total <= retired_total + {30'd0, retire_cnt};
  end
`else
  assign retired_total = '0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed vector bench for commit_unit: table of single-cycle retire cases plus
// reset, stats and halt sequences. Honours COMMIT_STATS_EN for retired_total.
module tb_commit_unit;
  import commit_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              h0_valid, h0_ready, h0_wb, h0_halt;
  logic [AREG_W-1:0] h0_rd;
  logic [DATA_W-1:0] h0_value;
  logic [TAG_W-1:0]  h0_tag;
  logic              h1_valid, h1_ready, h1_wb, h1_halt;
  logic [AREG_W-1:0] h1_rd;
  logic [DATA_W-1:0] h1_value;
  logic [TAG_W-1:0]  h1_tag;
  logic [1:0]        retire_cnt;
  logic              wen0, wen1, clr0_en, clr1_en, halted;
  logic [AREG_W-1:0] waddr0, waddr1, clr0_rd, clr1_rd;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [TAG_W-1:0]  clr0_tag, clr1_tag;
  logic [31:0]       retired_total;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk(clk), .rst(rst),
    .h0_valid(h0_valid), .h0_ready(h0_ready), .h0_wb(h0_wb), .h0_halt(h0_halt),
    .h0_rd(h0_rd), .h0_value(h0_value), .h0_tag(h0_tag),
    .h1_valid(h1_valid), .h1_ready(h1_ready), .h1_wb(h1_wb), .h1_halt(h1_halt),
    .h1_rd(h1_rd), .h1_value(h1_value), .h1_tag(h1_tag),
    .retire_cnt(retire_cnt),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .clr0_en(clr0_en), .clr0_rd(clr0_rd), .clr0_tag(clr0_tag),
    .clr1_en(clr1_en), .clr1_rd(clr1_rd), .clr1_tag(clr1_tag),
    .halted(halted), .retired_total(retired_total)
  );

  typedef struct {
    logic v0, r0, w0, hl0; logic [2:0] rd0; logic [15:0] val0; logic [5:0] tag0;
    logic v1, r1, w1, hl1; logic [2:0] rd1; logic [15:0] val1; logic [5:0] tag1;
    logic [1:0] cnt; logic wen0; logic wen1; logic halted;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // reference state: last written address/data/tag per slot and expected total
  logic [2:0]  m_a0, m_a1;
  logic [15:0] m_d0, m_d1;
  logic [5:0]  m_t0, m_t1;
  logic [31:0] m_total;
  bit          stats_on;

  function automatic vec_t mk(
      input logic v0, r0, w0, hl0, input logic [2:0] rd0, input logic [15:0] val0, input logic [5:0] tag0,
      input logic v1, r1, w1, hl1, input logic [2:0] rd1, input logic [15:0] val1, input logic [5:0] tag1,
      input logic [1:0] cnt, input logic e0, input logic e1, input logic hh);
    vec_t v;
    v.v0 = v0; v.r0 = r0; v.w0 = w0; v.hl0 = hl0; v.rd0 = rd0; v.val0 = val0; v.tag0 = tag0;
    v.v1 = v1; v.r1 = r1; v.w1 = w1; v.hl1 = hl1; v.rd1 = rd1; v.val1 = val1; v.tag1 = tag1;
    v.cnt = cnt; v.wen0 = e0; v.wen1 = e1; v.halted = hh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    h0_valid = v.v0; h0_ready = v.r0; h0_wb = v.w0; h0_halt = v.hl0;
    h0_rd = v.rd0; h0_value = v.val0; h0_tag = v.tag0;
    h1_valid = v.v1; h1_ready = v.r1; h1_wb = v.w1; h1_halt = v.hl1;
    h1_rd = v.rd1; h1_value = v.val1; h1_tag = v.tag1;
  endtask

  task automatic reset_model();
    m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0; m_t0 = '0; m_t1 = '0; m_total = '0;
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic apply(input vec_t v);
    drive(v);
    #1;
    chk("retire_cnt", {30'd0, retire_cnt}, {30'd0, v.cnt});
    @(posedge clk); #1;
    if (v.wen0) begin m_a0 = v.rd0; m_d0 = v.val0; m_t0 = v.tag0; end
    if (v.wen1) begin m_a1 = v.rd1; m_d1 = v.val1; m_t1 = v.tag1; end
    if (stats_on) m_total = m_total + {30'd0, v.cnt};
    chk("wen0", {31'd0, wen0}, {31'd0, v.wen0});
    chk("waddr0", {29'd0, waddr0}, {29'd0, m_a0});
    chk("wdata0", {16'd0, wdata0}, {16'd0, m_d0});
    chk("clr0_en", {31'd0, clr0_en}, {31'd0, v.wen0});
    chk("clr0_rd", {29'd0, clr0_rd}, {29'd0, m_a0});
    chk("clr0_tag", {26'd0, clr0_tag}, {26'd0, m_t0});
    chk("wen1", {31'd0, wen1}, {31'd0, v.wen1});
    chk("waddr1", {29'd0, waddr1}, {29'd0, m_a1});
    chk("wdata1", {16'd0, wdata1}, {16'd0, m_d1});
    chk("clr1_en", {31'd0, clr1_en}, {31'd0, v.wen1});
    chk("clr1_rd", {29'd0, clr1_rd}, {29'd0, m_a1});
    chk("clr1_tag", {26'd0, clr1_tag}, {26'd0, m_t1});
    chk("halted", {31'd0, halted}, {31'd0, v.halted});
    chk("retired_total", retired_total, m_total);
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_wen0", {31'd0, wen0}, 32'd0);
    chk("rst_wen1", {31'd0, wen1}, 32'd0);
    chk("rst_clr0_en", {31'd0, clr0_en}, 32'd0);
    chk("rst_clr1_en", {31'd0, clr1_en}, 32'd0);
    chk("rst_waddr0", {29'd0, waddr0}, 32'd0);
    chk("rst_wdata1", {16'd0, wdata1}, 32'd0);
    chk("rst_clr1_tag", {26'd0, clr1_tag}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_total", retired_total, 32'd0);
  endtask

  vec_t tbl[10];
  vec_t both, idle;

  initial begin
`ifdef COMMIT_STATS_EN
    stats_on = 1'b1;
`else
    stats_on = 1'b0;
`endif
    //           v r w h rd val      tag   v r w h rd val      tag   cnt w0 w1 hlt
    tbl[0] = mk(1,1,1,0,2,16'h1111,5,    1,1,1,0,3,16'h2222,6,    2, 1, 1, 0);
    tbl[1] = mk(1,1,1,0,4,16'hAAAA,7,    1,1,1,0,4,16'hBBBB,8,    2, 0, 1, 0);
    tbl[2] = mk(1,0,1,0,5,16'h0505,9,    1,1,1,0,6,16'h0606,10,   0, 0, 0, 0);
    tbl[3] = mk(1,1,1,0,5,16'h0505,9,    1,1,1,0,6,16'h0606,10,   2, 1, 1, 0);
    tbl[4] = mk(1,1,1,0,1,16'h1234,11,   0,1,1,0,2,16'hDEAD,12,   1, 1, 0, 0);
    tbl[5] = mk(1,1,0,0,3,16'hFFFF,13,   1,1,1,0,7,16'h7777,14,   2, 0, 1, 0);
    tbl[6] = mk(1,0,0,0,0,16'h0000,15,   1,1,1,0,1,16'h0001,16,   0, 0, 0, 0);
    tbl[7] = mk(1,1,1,0,6,16'h6666,17,   1,0,1,0,6,16'h9999,18,   1, 1, 0, 0);
    tbl[8] = mk(1,1,0,0,2,16'h3333,19,   1,1,1,0,2,16'h4444,20,   2, 0, 1, 0);
    tbl[9] = mk(0,1,1,0,3,16'h5555,21,   1,1,1,0,4,16'h5656,22,   0, 0, 0, 0);
    both   = mk(1,1,1,0,2,16'hC0DE,30,   1,1,1,0,5,16'hBEEF,31,   2, 1, 1, 0);
    idle   = mk(0,0,0,0,0,16'h0000,0,    0,0,0,0,0,16'h0000,0,    0, 0, 0, 0);

    rst = 1'b1;
    drive(idle);
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply(tbl[i]);

    // retires while rst is high are discarded
    drive(both);
    rst = 1'b1;
    #1;
    chk("rst_retire_cnt", {30'd0, retire_cnt}, 32'd0);
    @(posedge clk); #1;
    check_reset_state();
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    apply(both);

    // ten dual retires after a fresh reset
    rst = 1'b1;
    @(posedge clk);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) apply(both);
    chk("stats_total_10x2", retired_total, stats_on ? 32'd20 : 32'd0);

    // halt entry writes its result, blocks h1, then freezes retirement
    apply(mk(1,1,1,1,1,16'h0007,9,  1,1,1,0,3,16'h0033,10,  1, 1, 0, 1));
    apply(mk(1,1,1,0,4,16'h0044,11, 1,1,1,0,5,16'h0055,12,  0, 0, 0, 1));
    apply(mk(1,1,1,0,6,16'h0066,13, 1,1,1,0,7,16'h0077,14,  0, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have ports as listed; one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 hN_valid / hN_ready / hN_wb / hN_halt  in  1 each (N=0,1)  ROB head entry N present / result ready / writes a register / is halt.
REQ-005 hN_rd  in  3, hN_value  in  16, hN_tag  in  6 (N=0,1)  destination arch register, result, ROB index; h0 is oldest.
REQ-006 retire_cnt  out  2  entries retired this cycle (0..2), combinational; drives the ROB head advance.
REQ-007 wen0/wen1  out  1, waddr0/waddr1  out  3, wdata0/wdata1  out  16  register-file write ports, registered.
REQ-008 clrN_en  out  1, clrN_rd  out  3, clrN_tag  out  6 (N=0,1)  busy-clear request; rename logic clears busy only if its stored tag equals clrN_tag.
REQ-009 halted  out  1  high in HALTED state.
REQ-010 retired_total  out  32  count of retired entries.

Function
REQ-011 States: RUN, HALTED; RUN -> HALTED on the cycle a halt entry retires; HALTED left only by rst.
REQ-012 ret0 = RUN & h0_valid & h0_ready.
REQ-013 ret1 = ret0 & !h0_halt & h1_valid & h1_ready; h1 never retires without h0.
REQ-014 retire_cnt = ret0 + ret1; forced 0 in HALTED and while rst is high.
REQ-015 Write latency exactly 1 cycle: retire in cycle T -> wenN/waddrN/wdataN valid in T+1 for exactly one cycle.
REQ-016 Slot 0 carries h0 (wen0 = ret0 & h0_wb); slot 1 carries h1 (wen1 = ret1 & h1_wb).
REQ-017 Same-destination collapse: ret0 & ret1 & h0_wb & h1_wb & h0_rd==h1_rd -> wen0=0, wen1=1 with h1 data; only the younger value is written.
REQ-018 clrN_en/rd/tag registered identically to write slot N, including collapse (collapsed h0 issues no clear).
REQ-019 Halt entry with h0_wb still writes its result; entries behind it in the same cycle do not retire.
REQ-020 h0 not ready -> nothing retires, regardless of h1.
REQ-021 Ports idle (wen=0, clr_en=0) in every cycle not following a retire; data/address outputs hold last value when idle.
REQ-022 retired_total += retire_cnt each cycle; wraps modulo 2^32.

Reset
REQ-023 rst high at a rising edge: state=RUN, wen0=wen1=0, clr0_en=clr1_en=0, waddr/wdata/clr_rd/clr_tag=0, retired_total=0, halted=0.
REQ-024 Retires computed in a cycle with rst high are discarded: no write or clear issued in the following cycle.
REQ-025 First retire permitted in the first cycle with rst low.

Configuration
REQ-026 Macro COMMIT_STATS_EN defined: retired_total counter implemented per REQ-022.
REQ-027 COMMIT_STATS_EN undefined: no counter flops; retired_total tied to 0; all other behaviour unchanged.

Structure
REQ-028 Shared package commit_pkg holds DATA_W=16, AREG_W=3, TAG_W=6 and the RUN/HALTED state type.
REQ-029 One sub-module, commit_wb_slot, instantiated twice: registers one write port plus its busy-clear triple, with suppress input for collapse.

Verification
REQ-030 Both heads ready, h0 rd=2 val=0x1111 tag=5, h1 rd=3 val=0x2222 tag=6 -> retire_cnt=2; next cycle wen0 waddr0=2 wdata0=0x1111, wen1 waddr1=3 wdata1=0x2222, clr tags 5/6.
REQ-031 Both ready, rd=4 both, values 0xAAAA/0xBBBB -> retire_cnt=2; next cycle wen0=0, wen1=1 waddr1=4 wdata1=0xBBBB, clr0_en=0.
REQ-032 h0 not ready, h1 ready -> retire_cnt=0, no writes next cycle; then h0 ready -> retire_cnt=2.
REQ-033 h0 halt wb rd=1 val=0x0007, h1 ready -> retire_cnt=1; next cycle wen0 only, halted=1; later heads ready -> retire_cnt stays 0.
REQ-034 Retire in cycle T with rst high in T -> no wen/clr in T+1, retired_total=0, halted=0.
REQ-035 With COMMIT_STATS_EN: 10 cycles of dual retire -> retired_total=20; without: retired_total=0.
